// File: rtl/mem_burst_master_pkg.sv
// Shared FSM encoding and beat geometry for the burst master.
// Zero latency; pure declarations, no flow control.
package mem_burst_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int BYTES_PER_BEAT     = DEFAULT_DATA_WIDTH / 8;
    localparam int WORD_LSB           = $clog2(BYTES_PER_BEAT);

    function automatic int word_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/mem_burst_master_addr_gen.sv
// Burst address/beat counter: loads an aligned base and beat count, steps one beat per advance.
// Registered outputs, one-cycle update; caller paces it through advance.
module burst_addr_gen #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BURST_WIDTH = 4,
    parameter int STRIDE      = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   load,
    input  logic                   advance,
    input  logic [ADDR_WIDTH-1:0]  load_addr,
    input  logic [BURST_WIDTH-1:0] load_len,
    output logic [ADDR_WIDTH-1:0]  cur_addr,
    output logic                   last
);

    logic [BURST_WIDTH-1:0] beats_left;

    // Address arithmetic wraps naturally at 2**ADDR_WIDTH.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_addr   <= '0;
            beats_left <= '0;
        end else if (load) begin
            cur_addr   <= load_addr;
            beats_left <= load_len;
        end else if (advance) begin
            cur_addr <= cur_addr + ADDR_WIDTH'(STRIDE);
            if (beats_left != '0) begin
                beats_left <= beats_left - BURST_WIDTH'(1);
            end
        end
    end

    assign last = (beats_left == '0);

endmodule

// File: rtl/mem_burst_master.sv
// Bus initiator: one command becomes a burst of single-cycle slave accesses.
// Write beat per cycle, read beat per RD_LAT+1 cycles; start only honoured in IDLE.
module mem_burst_master
    import mem_burst_master_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_WIDTH = 4,
    parameter int RD_LAT      = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   mode,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_ack,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   wen,
    output logic                   ren,
    output logic [ADDR_WIDTH-1:0]  addr,
    output logic [DATA_WIDTH-1:0]  wdata,
    input  logic [DATA_WIDTH-1:0]  rdata
);

    localparam int BPB  = DATA_WIDTH / 8;
    localparam int WLSB = word_lsb(DATA_WIDTH);

    state_t                  state_q, state_d;
    logic [2:0]              wait_q;
    logic                    wait_done;
    logic                    load, advance, last;
    logic [ADDR_WIDTH-1:0]   cur_addr, aligned_base;

    assign aligned_base = (base_addr >> WLSB) << WLSB;
    assign wait_done    = (wait_q == 3'(RD_LAT));
    assign load         = (state_q == ST_IDLE) && start;
    assign advance      = (state_q == ST_WRITE) || ((state_q == ST_READ) && wait_done);

    burst_addr_gen #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BURST_WIDTH (BURST_WIDTH),
        .STRIDE      (BPB)
    ) u_addr_gen (
        .clk       (clk),
        .rstn      (rstn),
        .load      (load),
        .advance   (advance),
        .load_addr (aligned_base),
        .load_len  (burst_len),
        .cur_addr  (cur_addr),
        .last      (last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = mode ? ST_WRITE : ST_READ;
            ST_WRITE: if (last) state_d = ST_DONE;
            ST_READ:  if (wait_done && last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The last read beat's rd_valid lands in the DONE cycle alongside done.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_valid <= (state_q == ST_READ) && wait_done;
            if ((state_q == ST_READ) && wait_done) begin
                rd_data <= rdata;
            end
            if ((state_q == ST_READ) && !wait_done) begin
                wait_q <= wait_q + 3'd1;
            end else begin
                wait_q <= '0;
            end
        end
    end

    assign wen    = (state_q == ST_WRITE);
    assign ren    = (state_q == ST_READ);
    assign wr_ack = wen;
    assign busy   = wen || ren;
    assign done   = (state_q == ST_DONE);
    assign addr   = busy ? cur_addr : '0;
    assign wdata  = wen ? wr_data : '0;

endmodule
